final_adder: RTL and testbench



---
 rtl/adder_pkg.sv | 6 +
 rtl/cla4.sv | 23 ++
 rtl/final_adder.sv | 56 +++++
 tb/tb_final_adder.sv | 74 +++++++
 4 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: shared widths for the carry-lookahead final adder
package adder_pkg;
  localparam int ADD_WIDTH = 16;
  localparam int GROUP_W = 4;
  localparam int N_GROUPS = ADD_WIDTH / GROUP_W;
endpackage

// File: rtl/cla4.sv
// cla4: 4-bit carry-lookahead group with group generate/propagate outputs
module cla4
  import adder_pkg::*;
(
  input  logic [GROUP_W-1:0] a,
  input  logic [GROUP_W-1:0] b,
  input  logic               cin,
  output logic [GROUP_W-1:0] sum,
  output logic               gg,
  output logic               gp
);
  logic [GROUP_W-1:0] g, p, c;
  assign g = a & b;
  assign p = a ^ b;
  // gg/gp depend only on a,b so the second level never waits on cin
  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign gp = &p;
  assign c = {g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin),
              g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin),
              g[0] | (p[0] & cin),
              cin};
  assign sum = p ^ c;
endmodule

// File: rtl/final_adder.sv
// final_adder: registered two-level carry-lookahead adder, {c4, s} = x + y + c0
module final_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c0,
  output logic [WIDTH-1:0] s,
  output logic             c4
);
  localparam int NG = WIDTH / GROUP_W;
  logic [NG-1:0] gg, gp;
  logic [NG:0] cg;
  logic [WIDTH-1:0] sum_w, s_d, s_q;
  logic c4_d, c4_q, term;
  for (genvar i = 0; i < NG; i++) begin : g_grp
    cla4 u_cla4 (
      .a   (x[GROUP_W*i +: GROUP_W]),
      .b   (y[GROUP_W*i +: GROUP_W]),
      .cin (cg[i]),
      .sum (sum_w[GROUP_W*i +: GROUP_W]),
      .gg  (gg[i]),
      .gp  (gp[i])
    );
  end
  // Each group carry is a flat sum of products of (G,P) and c0, no inter-group ripple
  always_comb begin
    cg = '0;
    term = 1'b0;
    cg[0] = c0;
    for (int k = 0; k < NG; k++) begin
      for (int j = -1; j <= k; j++) begin
        term = (j < 0) ? c0 : gg[j];
        for (int m = j + 1; m <= k; m++) term = term & gp[m];
        cg[k+1] = cg[k+1] | term;
      end
    end
    s_d = sum_w;
    c4_d = cg[NG];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q <= '0;
      c4_q <= 1'b0;
    end else begin
      s_q <= s_d;
      c4_q <= c4_d;
    end
  end
  assign s = s_q;
  assign c4 = c4_q;
endmodule

// File: tb/tb_final_adder.sv
// tb_final_adder: scoreboard bench for final_adder with directed and random vectors
module tb_final_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] x = '0, y = '0;
  logic c0 = 1'b0;
  logic [15:0] s;
  logic c4;
  logic [16:0] exp_q[$];
  int n_chk = 0, n_pass = 0;

  final_adder dut (.clk(clk), .rst(rst), .x(x), .y(y), .c0(c0), .s(s), .c4(c4));

  always #5 clk = ~clk;

  function automatic void check(string name, logic [16:0] got, logic [16:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s got {c4,s}=%h want %h", name, got, want);
  endfunction

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic c);
    @(negedge clk);
    x = a;
    y = b;
    c0 = c;
    exp_q.push_back({1'b0, a} + {1'b0, b} + {16'd0, c});
  endtask

  // monitor: every cycle the register shows the previous cycle's sample
  always @(posedge clk) begin
    logic [16:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sum", {c4, s}, e);
    end
  end

  initial begin
    #1;
    check("reset_initial", {c4, s}, 17'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(16'h1A33, 16'hE5EB, 1'b0);
    drive(16'hFFFF, 16'h0000, 1'b1);
    drive(16'hFFFF, 16'hFFFF, 1'b1);
    drive(16'h0000, 16'h0000, 1'b0);
    drive(16'h0F0F, 16'h00F1, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("reset_async", {c4, s}, 17'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold", {c4, s}, 17'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(16'h0001, 16'h0001, 1'b1);
    for (int i = 0; i < 10000; i++)
      drive(16'($urandom), 16'($urandom), 1'($urandom));
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_chk++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
